dmem_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared single-ported data-memory/IO bus (word RAM in addr[6:2] plus IO window at addr[7]=1).
- Master 0 is the CPU load/store port; master 1 is a secondary bus master, e.g. an IO scan/DMA engine.
- Grants the bus round-robin and drives registered address, write-data and write-enable to the memory for one transaction at a time.
- Returns read data with a one-cycle ack pulse.

---
 rtl/dmem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: two-master arbiter/sequencer for the shared data-memory/IO bus.
// Each granted transaction walks IDLE -> ADDR -> DATA -> RESP -> IDLE, one cycle per
// non-idle state, with registered memory-side outputs and a one-cycle ack to the winner.
// Contention is resolved round-robin by default.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: master 0 always wins a simultaneous request.
module dmem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          we_lat_q, we_lat_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          busy_q, busy_d;
    logic          any_req;
    logic          winner;

    // Pick the master that would win if the bus were granted this cycle.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant_q;
`endif
        end else begin
            winner = m1_req;
        end
    end

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        we_lat_d     = we_lat_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = ADDR;
                    grant_d      = winner;
                    last_grant_d = winner;
                    mem_addr_d   = winner ? m1_addr  : m0_addr;
                    mem_wdata_d  = winner ? m1_wdata : m0_wdata;
                    we_lat_d     = winner ? m1_we    : m0_we;
                    mem_we_d     = winner ? m1_we    : m0_we;
                end
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                state_d = RESP;
                if (!we_lat_q) begin
                    if (grant_q) begin
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_rdata_d = mem_rdata;
                    end
                end
                if (grant_q) begin
                    m1_ack_d = 1'b1;
                end else begin
                    m0_ack_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Register all state and outputs; reset aborts any transaction without an ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            we_lat_q     <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            we_lat_q     <= we_lat_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Testbench for dmem_bus_arbiter: a small memory model answers bus reads, expected
// acks/read data are queued when requests are driven and popped as acks appear.
module tb_dmem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        grant, busy;

    typedef struct {
        int          master;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] rmodel0      = 32'h0;
    logic [31:0] rmodel1      = 32'h0;

    logic [31:0] ram [0:63];
    bit          written [0:63];
    int          we_total  = 0;
    int          we_double = 0;
    logic        we_prev   = 1'b0;
    logic [31:0] we_last_addr;
    logic [31:0] we_last_data;

    dmem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Initial memory image for words the bench has not written.
    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            2:       return 32'h12345678;
            3:       return 32'h33333333;
            4:       return 32'h11110000;
            5:       return 32'h22220000;
            default: return 32'h0;
        endcase
    endfunction

    assign mem_rdata = written[mem_addr[7:2]] ? ram[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));

    // Memory model write port.
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr[7:2]]     <= mem_wdata;
            written[mem_addr[7:2]] <= 1'b1;
        end
    end

    // Bus monitor: counts write strobes and back-to-back write strobes.
    always @(negedge clock) begin
        if (mem_we) begin
            we_total++;
            we_last_addr = mem_addr;
            we_last_data = mem_wdata;
            if (we_prev) we_double++;
        end
        we_prev = mem_we;
    end

    task automatic wait_ack(input int max_cycles, output int which, output int cycles);
        which  = -1;
        cycles = 0;
        while (which < 0 && cycles < max_cycles) begin
            @(negedge clock);
            cycles++;
            if (m0_ack) which = 0;
            else if (m1_ack) which = 1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        #12;
        tests_run++;
        if ({mem_addr, mem_wdata, mem_we} !== 65'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem: got addr=%h wdata=%h we=%b expected all 0", mem_addr, mem_wdata, mem_we);
        end
        tests_run++;
        if ({m0_ack, m1_ack, grant, busy} !== 4'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got acks=%b%b grant=%b busy=%b rd0=%h rd1=%h expected all 0",
                     m0_ack, m1_ack, grant, busy, m0_rdata, m1_rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read();
        int   which, cycles;
        exp_t e;
        @(posedge clock); #1;
        m0_addr = 32'h8; m0_we = 0; m0_req = 1;
        rmodel0 = 32'h12345678;
        exp_q.push_back('{master: 0, rdata: rmodel0});
        wait_ack(12, which, cycles);
        m0_req = 0;
        tests_run++;
        if (which !== 0 || cycles !== 4) begin
            tests_failed++;
            $display("[TB] FAIL read_latency: got master=%0d cycles=%0d expected master=0 cycles=4", which, cycles);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (m0_rdata !== e.rdata || m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_data: got rdata=%h m1_ack=%b expected %h and 0", m0_rdata, m1_ack, e.rdata);
        end
        @(negedge clock);
        tests_run++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0 || m1_rdata !== rmodel1) begin
            tests_failed++;
            $display("[TB] FAIL read_pulse: got m0_ack=%b m1_ack=%b busy=%b m1_rdata=%h expected 0 0 0 %h",
                     m0_ack, m1_ack, busy, m1_rdata, rmodel1);
        end
    endtask

    task automatic test_write();
        int   which, cycles, we_start;
        exp_t e;
        we_start = we_total;
        @(posedge clock); #1;
        m1_addr = 32'h80; m1_wdata = 32'hA5A5A5A5; m1_we = 1; m1_req = 1;
        exp_q.push_back('{master: 1, rdata: rmodel1});
        wait_ack(12, which, cycles);
        m1_req = 0; m1_we = 0;
        e = exp_q.pop_front();
        tests_run++;
        if (which !== e.master || m1_rdata !== e.rdata || m0_rdata !== rmodel0) begin
            tests_failed++;
            $display("[TB] FAIL write_ack: got master=%0d m1_rdata=%h m0_rdata=%h expected %0d %h %h",
                     which, m1_rdata, m0_rdata, e.master, e.rdata, rmodel0);
        end
        tests_run++;
        if (we_total - we_start !== 1 || we_last_addr !== 32'h80 || we_last_data !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("[TB] FAIL write_strobe: got count=%0d addr=%h data=%h expected 1 00000080 a5a5a5a5",
                     we_total - we_start, we_last_addr, we_last_data);
        end
        tests_run++;
        if (ram[32] !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("[TB] FAIL write_mem: got %h expected a5a5a5a5", ram[32]);
        end
    endtask

    task automatic test_back_to_back();
        int   which, cycles, m;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            m = 0;
`else
            m = i % 2;
`endif
            exp_q.push_back('{master: m, rdata: (m == 0) ? 32'h11110000 : 32'h22220000});
        end
        @(posedge clock); #1;
        m0_addr = 32'h10; m0_we = 0; m0_req = 1;
        m1_addr = 32'h14; m1_we = 0; m1_req = 1;
        for (int i = 0; i < 8; i++) begin
            wait_ack(12, which, cycles);
            if (i == 7) begin
                m0_req = 0; m1_req = 0;
            end
            e = exp_q.pop_front();
            if (which == 0) rmodel0 = m0_rdata;
            if (which == 1) rmodel1 = m1_rdata;
            tests_run++;
            if (which !== e.master || cycles !== 4 ||
                (which == 0 && m0_rdata !== e.rdata) || (which == 1 && m1_rdata !== e.rdata)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d: got master=%0d cycles=%0d rd0=%h rd1=%h expected master=%0d cycles=4 rdata=%h",
                         i, which, cycles, m0_rdata, m1_rdata, e.master, e.rdata);
            end
        end
        rmodel0 = 32'h11110000;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rmodel1 = 32'h22220000;
`endif
        repeat (6) @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: got busy=%b acks=%b%b expected 0 00", busy, m0_ack, m1_ack);
        end
    endtask

    task automatic test_withdraw();
        int   which, cycles, we_start, extra;
        exp_t e;
        we_start = we_total;
        @(posedge clock); #1;
        m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF; m0_we = 1; m0_req = 1;
        exp_q.push_back('{master: 0, rdata: rmodel0});
        @(posedge clock); #1;
        m0_req = 0; m0_we = 0;
        wait_ack(12, which, cycles);
        e = exp_q.pop_front();
        tests_run++;
        if (which !== e.master || m0_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL withdraw_ack: got master=%0d rdata=%h expected %0d %h", which, m0_rdata, e.master, e.rdata);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clock);
            if (m0_ack || m1_ack) extra++;
        end
        tests_run++;
        if (we_total - we_start !== 1 || ram[8] !== 32'hDEADBEEF || extra !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL withdraw_write: got strobes=%0d mem=%h extra_acks=%0d busy=%b expected 1 deadbeef 0 0",
                     we_total - we_start, ram[8], extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        int   which, cycles, acks;
        exp_t e;
        @(posedge clock); #1;
        m1_addr = 32'hC; m1_we = 0; m1_req = 1;
        @(posedge clock);
        @(posedge clock); #1;
        tests_run++;
        if (busy !== 1'b1 || grant !== 1'b1 || mem_addr !== 32'hC || mem_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_data: got busy=%b grant=%b addr=%h we=%b expected 1 1 0000000c 0",
                     busy, grant, mem_addr, mem_we);
        end
        reset = 1'b1;
        #1;
        rmodel0 = 32'h0;
        rmodel1 = 32'h0;
        tests_run++;
        if ({mem_addr, mem_wdata, mem_we, m0_ack, m1_ack, grant, busy} !== 69'h0 ||
            m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_values: got addr=%h wd=%h we=%b acks=%b%b grant=%b busy=%b rd0=%h rd1=%h expected all 0",
                     mem_addr, mem_wdata, mem_we, m0_ack, m1_ack, grant, busy, m0_rdata, m1_rdata);
        end
        m1_req = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            if (m0_ack || m1_ack) acks++;
        end
        tests_run++;
        if (acks !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_noack: got %0d acks expected 0", acks);
        end
        @(posedge clock); #1;
        m0_addr = 32'h8; m0_we = 0; m0_req = 1;
        m1_addr = 32'hC; m1_we = 0; m1_req = 1;
        rmodel0 = 32'h12345678;
        exp_q.push_back('{master: 0, rdata: rmodel0});
        wait_ack(12, which, cycles);
        m0_req = 0; m1_req = 0;
        e = exp_q.pop_front();
        tests_run++;
        if (which !== e.master || m0_rdata !== e.rdata || m1_rdata !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_first: got master=%0d rd0=%h rd1=%h expected %0d %h 00000000",
                     which, m0_rdata, m1_rdata, e.master, e.rdata);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_hold_through_resp();
        int   pos[$];
        int   m1_acks, p;
        exp_t e;
        @(posedge clock); #1;
        m0_addr = 32'h8; m0_we = 0; m0_req = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{master: 0, rdata: 32'h12345678});
        m1_acks = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (m0_ack) begin
                pos.push_back(n);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    tests_run++;
                    if (m0_rdata !== e.rdata) begin
                        tests_failed++;
                        $display("[TB] FAIL hold_data: got %h expected %h", m0_rdata, e.rdata);
                    end
                end
            end
            if (m1_ack) m1_acks++;
            if (n == 12) m0_req = 0;
        end
        tests_run++;
        if (pos.size() !== 3 || m1_acks !== 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_count: got %0d m0 acks %0d m1 acks expected 3 and 0", pos.size(), m1_acks);
        end
        for (int i = 0; i < pos.size() && i < 3; i++) begin
            p = pos[i];
            tests_run++;
            if (p !== 4 * (i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL hold_spacing_%0d: got cycle %0d expected %0d", i, p, 4 * (i + 1));
            end
        end
        exp_q.delete();
        repeat (5) @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || m0_ack !== 1'b0 || we_double !== 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_idle: got busy=%b ack=%b double_we=%0d expected 0 0 0", busy, m0_ack, we_double);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_withdraw();
        test_reset_mid();
        test_hold_through_resp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit in case the DUT or bench stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
